instruction_fetch_unit: RTL and testbench

Upstream feeder for `control_unit`: holds the program counter and a small program-loadable instruction memory. Fetches one 32-bit instruction at a time and presents it through a valid/ready handshake. `control_unit` consumes it and signals readiness when it returns to its idle state (s0). A dedicated HALT opcode stops fetching, so a bench can run a finite LW/SW/ADD/SUB program end-to-end.

---
 rtl/cpu_defs.sv | 25 ++
 rtl/instruction_rom.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: full-word opcodes used by the fetch unit and control_unit,
// the default instruction width, and the fetch FSM state encoding.
package cpu_defs;

  localparam int DEFAULT_SIZE = 32;

  localparam logic [31:0] OP_LW   = 32'h0000_0000;
  localparam logic [31:0] OP_SW   = 32'h0000_0001;
  localparam logic [31:0] OP_ADD  = 32'h0000_0002;
  localparam logic [31:0] OP_SUB  = 32'h0000_0003;
  localparam logic [31:0] OP_HALT = 32'hFFFF_FFFF;

  localparam logic [1:0] FS_IDLE  = 2'd0;
  localparam logic [1:0] FS_FETCH = 2'd1;
  localparam logic [1:0] FS_ISSUE = 2'd2;
  localparam logic [1:0] FS_HALT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = FS_IDLE,
    ST_FETCH = FS_FETCH,
    ST_ISSUE = FS_ISSUE,
    ST_HALT  = FS_HALT
  } fetch_state_t;

endpackage

// File: rtl/instruction_rom.sv
// Program-loadable instruction store: one synchronous write port and one
// enabled synchronous read port with write-first forwarding. No reset.
module instruction_rom #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE-1:0]       wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [SIZE-1:0]       rd_data
);

  logic [SIZE-1:0] mem [DEPTH];

  // Forwarding lets a write and a read of the same word on one edge return the new data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: PC, instruction register and IDLE/FETCH/ISSUE/HALT sequencer feeding
// control_unit through a valid/ready handshake.
module instruction_fetch_unit
  import cpu_defs::*;
#(
  parameter int SIZE       = DEFAULT_SIZE,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  prog_write_enable,
  input  logic [ADDR_WIDTH-1:0] prog_write_addr,
  input  logic [SIZE-1:0]       prog_write_data,
  input  logic                  instr_ready,
  output logic [SIZE-1:0]       instruction,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic [1:0]            fsm_state
);

  // Handshake: a transfer happens on a rising edge where instr_valid && instr_ready;
  // once raised, instr_valid and instruction hold until that transfer (or reset).

  fetch_state_t          state;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [SIZE-1:0]       rd_data;

  assign fsm_state = state;
  assign wr_en     = prog_write_enable && ((state == ST_IDLE) || (state == ST_HALT));

  // The memory is addressed on the edge that enters FETCH, so its word is
  // available during FETCH for the HALT check and the register load.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = pc;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          rd_en   = 1'b1;
          rd_addr = '0;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          rd_en   = 1'b1;
          rd_addr = pc + ADDR_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  instruction_rom #(
    .SIZE       (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rom (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (prog_write_addr),
    .wr_data (prog_write_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
            pc    <= '0;
          end
        end
        ST_FETCH: begin
          instruction <= rd_data;
          if (rd_data == SIZE'(OP_HALT)) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state       <= ST_ISSUE;
            instr_valid <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            state       <= ST_FETCH;
            pc          <= pc + ADDR_WIDTH'(1);
            instr_valid <= 1'b0;
          end
        end
        ST_HALT: begin
          if (start) begin
            state  <= ST_FETCH;
            pc     <= '0;
            halted <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table-driven program run plus
// hand-written backpressure, write-gating, wrap-around and reset sequences.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        prog_write_enable = 1'b0;
  logic [4:0]  prog_write_addr = '0;
  logic [31:0] prog_write_data = '0;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        halted;
  logic [1:0]  fsm_state;

  int tests_run = 0;
  int tests_failed = 0;
  int halt_leak = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic [4:0]  exp_pc;
    logic [31:0] exp_instr;
    logic        chk_instr;
    logic        exp_halted;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[11];

  instruction_fetch_unit #(.SIZE(32), .ADDR_WIDTH(5), .DEPTH(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .prog_write_enable (prog_write_enable),
    .prog_write_addr   (prog_write_addr),
    .prog_write_data   (prog_write_data),
    .instr_ready       (instr_ready),
    .instruction       (instruction),
    .instr_valid       (instr_valid),
    .pc                (pc),
    .halted            (halted),
    .fsm_state         (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // The HALT word must never be offered as a valid instruction.
  always @(negedge clk) begin
    if (reset_n && instr_valid && instruction == 32'hFFFF_FFFF) halt_leak++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks: all entered and left just after a falling edge
  task automatic load_word(input logic [4:0] addr, input logic [31:0] data);
    prog_write_enable = 1'b1;
    prog_write_addr   = addr;
    prog_write_data   = data;
    @(negedge clk);
    prog_write_enable = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, instr_valid}, 32'd1);
  endtask

  // Runs the program with instr_ready=1 and records every presented word.
  task automatic run_to_halt(input string name);
    int n = 0;
    got_q.delete();
    instr_ready = 1'b1;
    pulse_start();
    while (!halted && n < 200) begin
      if (instr_valid) got_q.push_back(instruction);
      @(negedge clk);
      n++;
    end
    check({name, "_halted"}, {31'd0, halted}, 32'd1);
    check({name, "_halt_pc"}, {27'd0, pc}, 32'd4);
  endtask

  // scoreboard compare of presented words against exp_q
  task automatic compare_q(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", name, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_instruction", instruction, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", {27'd0, pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    load_word(5'd0, 32'd0);
    load_word(5'd1, 32'd1);
    load_word(5'd2, 32'd2);
    load_word(5'd3, 32'd3);
    load_word(5'd4, 32'hFFFF_FFFF);

    // program sequence, one row per cycle
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 2'd1};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 1'b0, 2'd2};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 2'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 5'd1, 32'd1, 1'b1, 1'b0, 2'd2};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd2, 32'd1, 1'b1, 1'b0, 2'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 5'd2, 32'd2, 1'b1, 1'b0, 2'd2};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'd3, 32'd2, 1'b1, 1'b0, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 5'd3, 32'd3, 1'b1, 1'b0, 2'd2};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'd4, 32'd3, 1'b1, 1'b0, 2'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'd4, 32'd0, 1'b0, 1'b1, 2'd3};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 5'd4, 32'd0, 1'b0, 1'b1, 2'd3};

    for (int i = 0; i < 11; i++) begin
      start       = vecs[i].start;
      instr_ready = vecs[i].ready;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("prog%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("prog%0d_pc", i), {27'd0, pc}, {27'd0, vecs[i].exp_pc});
      check($sformatf("prog%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
      check($sformatf("prog%0d_state", i), {30'd0, fsm_state}, {30'd0, vecs[i].exp_state});
      if (vecs[i].chk_instr)
        check($sformatf("prog%0d_instr", i), instruction, vecs[i].exp_instr);
    end

    // backpressure on word 2, with a stray start that must be ignored
    instr_ready = 1'b1;
    pulse_start();
    for (int n = 0; n < 20 && !(instr_valid && pc == 5'd2); n++) @(negedge clk);
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      @(negedge clk);
      start = 1'b0;
      check($sformatf("bp%0d_valid", k), {31'd0, instr_valid}, 32'd1);
      check($sformatf("bp%0d_pc", k), {27'd0, pc}, 32'd2);
      check($sformatf("bp%0d_instr", k), instruction, 32'd2);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("bp_xfer_valid", {31'd0, instr_valid}, 32'd0);
    check("bp_xfer_pc", {27'd0, pc}, 32'd3);
    repeat (2) @(negedge clk);
    check("bp_single_pc", {27'd0, pc}, 32'd3);
    check("bp_single_instr", instruction, 32'd3);
    instr_ready = 1'b1;
    wait_halted("bp_reach_halt", 20);

    // write gating: writes during FETCH/ISSUE are dropped
    instr_ready = 1'b1;
    pulse_start();
    prog_write_enable = 1'b1;
    prog_write_addr   = 5'd1;
    prog_write_data   = 32'd3;
    repeat (3) @(negedge clk);
    prog_write_enable = 1'b0;
    wait_halted("wg_reach_halt", 30);
    run_to_halt("wg_run1");
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3};
    compare_q("wg_run1");
    load_word(5'd1, 32'd3);
    run_to_halt("wg_run2");
    exp_q = '{32'd0, 32'd3, 32'd2, 32'd3};
    compare_q("wg_run2");

    // wrap-around over all 32 entries
    for (int a = 0; a < 32; a++) load_word(5'(a), 32'd2);
    begin
      int count = 0;
      int n = 0;
      instr_ready = 1'b1;
      pulse_start();
      while (count < 33 && n < 200) begin
        if (instr_valid) begin
          check($sformatf("wrap%0d_pc", count), {27'd0, pc}, 32'(count % 32));
          check($sformatf("wrap%0d_instr", count), instruction, 32'd2);
          count++;
        end
        @(negedge clk);
        n++;
      end
      check("wrap_count", count, 32'd33);
    end

    // asynchronous reset in the middle of ISSUE
    instr_ready = 1'b0;
    wait_valid("ar_reach_issue", 10);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, instr_valid}, 32'd0);
    check("ar_pc", {27'd0, pc}, 32'd0);
    check("ar_instr", instruction, 32'd0);
    check("ar_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    pulse_start();
    wait_valid("ar_restart", 10);
    check("ar_restart_pc", {27'd0, pc}, 32'd0);
    check("ar_mem_intact", instruction, 32'd2);

    // write and start together in IDLE: first fetch sees the new word
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    prog_write_enable = 1'b1;
    prog_write_addr   = 5'd0;
    prog_write_data   = 32'hABCD_0001;
    start             = 1'b1;
    @(negedge clk);
    prog_write_enable = 1'b0;
    start             = 1'b0;
    wait_valid("ws_valid", 10);
    check("ws_pc", {27'd0, pc}, 32'd0);
    check("ws_instr", instruction, 32'hABCD_0001);

    check("halt_never_valid", halt_leak, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
